wb_burst_ram_slave: RTL and testbench

//  Wishbone B3 slave that answers the orlink bus master: an on-chip 32-bit RAM with byte lanes.

---
 rtl/orlink_wb_pkg.sv | 25 ++
 rtl/wb_burst_ram_mem.sv | 34 +++
 rtl/wb_burst_ram_slave.sv | 142 ++++++++++++++
 tb/tb_wb_burst_ram_slave.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/orlink_wb_pkg.sv
// Shared Wishbone encodings for the orlink bus and the on-chip RAM slave FSM.
package orlink_wb_pkg;

   // Cycle type identifiers (wb_cti_i)
   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_CONST   = 3'b001;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   // Burst type extensions (wb_bte_i)
   typedef enum logic [1:0] {
      BTE_LINEAR = 2'b00,
      BTE_WRAP4  = 2'b01,
      BTE_WRAP8  = 2'b10,
      BTE_WRAP16 = 2'b11
   } bte_e;

   // Slave FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ACK  = 2'b01,
      ST_ERR  = 2'b10
   } state_e;

endpackage

// File: rtl/wb_burst_ram_mem.sv
// Single-port synchronous RAM, 2^AW x 32, with per-byte write enables.
// Ports: clk; en enables the access; adr word address; we byte-write lanes
// (any lane set makes this a write, read output then holds); wdat write data;
// rdat registered read data.
module wb_burst_ram_mem #(
   parameter int unsigned AW = 6
) (
   input  logic          clk,
   input  logic          en,
   input  logic [AW-1:0] adr,
   input  logic [3:0]    we,
   input  logic [31:0]   wdat,
   output logic [31:0]   rdat
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [31:0] mem [DEPTH];

   // Write has priority on the shared port; the read register only updates on pure reads
   always_ff @(posedge clk) begin
      if (en) begin
         if (we == 4'b0000) begin
            rdat <= mem[adr];
         end
         for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
               mem[adr][8*i +: 8] <= wdat[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/wb_burst_ram_slave.sv
// Wishbone B3 RAM slave for the orlink master: classic cycles plus
// registered-feedback linear and wrap-4/8/16 bursts, one beat per clock.
// Ports: wb_clk, rst_n (async active-low); wb_adr_i byte address; wb_dat_i
// write data; wb_sel_i byte lanes; wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i,
// wb_bte_i bus controls; wb_dat_o read data (valid with ack); wb_ack_o
// acknowledge; wb_err_o out-of-range error; wb_rty_o tied low.
module wb_burst_ram_slave
   import orlink_wb_pkg::*;
#(
   parameter int unsigned MEM_SIZE_BYTES = 256,
   parameter int unsigned MEM_ADR_WIDTH  = 6
) (
   input  logic        wb_clk,
   input  logic        rst_n,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic [2:0]  wb_cti_i,
   input  logic [1:0]  wb_bte_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        wb_err_o,
   output logic        wb_rty_o
);

   localparam int unsigned AW = MEM_ADR_WIDTH;

   state_e        state_q, state_d;
   logic [AW-1:0] cur_adr_q, cur_adr_d;
   logic          we_q, we_d;

   logic          ack_c;
   logic          in_range_c;
   logic          last_lin_c;
   logic [AW-1:0] nxt_adr_c;
   logic          mem_en_c;
   logic [AW-1:0] mem_adr_c;
   logic [3:0]    mem_we_c;
   logic [31:0]   mem_rdat;

   assign in_range_c = wb_adr_i < 32'(MEM_SIZE_BYTES);
   assign ack_c      = (state_q == ST_ACK) & wb_cyc_i & wb_stb_i;

   assign wb_ack_o = ack_c;
   assign wb_err_o = (state_q == ST_ERR);
   assign wb_rty_o = 1'b0;
   assign wb_dat_o = ack_c ? mem_rdat : 32'h0000_0000;

   // Next burst address; linear bursts flag the top word so they error instead of wrapping
   always_comb begin
      nxt_adr_c  = cur_adr_q + AW'(1);
      last_lin_c = 1'b0;
      case (wb_bte_i)
         BTE_LINEAR: last_lin_c = &cur_adr_q;
         BTE_WRAP4:  nxt_adr_c  = {cur_adr_q[AW-1:2], cur_adr_q[1:0] + 2'd1};
         BTE_WRAP8:  nxt_adr_c  = {cur_adr_q[AW-1:3], cur_adr_q[2:0] + 3'd1};
         BTE_WRAP16: nxt_adr_c  = {cur_adr_q[AW-1:4], cur_adr_q[3:0] + 4'd1};
         default:    last_lin_c = 1'b0;
      endcase
   end

   // Next state and RAM port control
   always_comb begin
      state_d   = state_q;
      cur_adr_d = cur_adr_q;
      we_d      = we_q;
      mem_en_c  = 1'b0;
      mem_adr_c = cur_adr_q;
      mem_we_c  = 4'b0000;
      case (state_q)
         ST_IDLE: begin
            if (wb_cyc_i && wb_stb_i) begin
               if (!in_range_c) begin
                  state_d = ST_ERR;
               end else begin
                  state_d   = ST_ACK;
                  mem_en_c  = 1'b1;
                  mem_adr_c = wb_adr_i[AW+1:2];
                  cur_adr_d = wb_adr_i[AW+1:2];
                  we_d      = wb_we_i;
               end
            end
         end
         ST_ACK: begin
            if (!wb_cyc_i) begin
               state_d = ST_IDLE;
            end else if (ack_c) begin
               if (we_q) begin
                  mem_en_c = 1'b1;
                  mem_we_c = wb_sel_i;
               end
               case (wb_cti_i)
                  CTI_INCR: begin
                     if (last_lin_c) begin
                        state_d = ST_ERR;
                     end else begin
                        cur_adr_d = nxt_adr_c;
                        // Prefetch the next beat; write bursts never need read data
                        if (!we_q) begin
                           mem_en_c  = 1'b1;
                           mem_adr_c = nxt_adr_c;
                        end
                     end
                  end
                  CTI_CLASSIC, CTI_CONST, CTI_EOB: state_d = ST_IDLE;
                  default:                         state_d = ST_IDLE;
               endcase
            end
         end
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and burst context registers
   always_ff @(posedge wb_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cur_adr_q <= '0;
         we_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_adr_q <= cur_adr_d;
         we_q      <= we_d;
      end
   end

   wb_burst_ram_mem #(
      .AW (AW)
   ) u_mem (
      .clk  (wb_clk),
      .en   (mem_en_c),
      .adr  (mem_adr_c),
      .we   (mem_we_c),
      .wdat (wb_dat_i),
      .rdat (mem_rdat)
   );

endmodule

// File: tb/tb_wb_burst_ram_slave.sv
// Directed bench for wb_burst_ram_slave: driver pushes expected responses,
// a negedge monitor pops and compares every ack/err the slave presents.
module tb_wb_burst_ram_slave;
   import orlink_wb_pkg::*;

   logic        wb_clk = 1'b0;
   logic        rst_n;
   logic [31:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [3:0]  wb_sel_i;
   logic        wb_we_i;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic [2:0]  wb_cti_i;
   logic [1:0]  wb_bte_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;
   logic        wb_err_o;
   logic        wb_rty_o;

   typedef struct packed {
      logic        is_err;
      logic        chk;
      logic [31:0] dat;
   } exp_t;

   exp_t sb[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   always #5 wb_clk = ~wb_clk;

   wb_burst_ram_slave #(
      .MEM_SIZE_BYTES (256),
      .MEM_ADR_WIDTH  (6)
   ) dut (
      .wb_clk   (wb_clk),
      .rst_n    (rst_n),
      .wb_adr_i (wb_adr_i),
      .wb_dat_i (wb_dat_i),
      .wb_sel_i (wb_sel_i),
      .wb_we_i  (wb_we_i),
      .wb_cyc_i (wb_cyc_i),
      .wb_stb_i (wb_stb_i),
      .wb_cti_i (wb_cti_i),
      .wb_bte_i (wb_bte_i),
      .wb_dat_o (wb_dat_o),
      .wb_ack_o (wb_ack_o),
      .wb_err_o (wb_err_o),
      .wb_rty_o (wb_rty_o)
   );

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic is_err, input logic chk, input logic [31:0] dat);
      exp_t e;
      e.is_err = is_err;
      e.chk    = chk;
      e.dat    = dat;
      return e;
   endfunction

   // Monitor: every response the slave shows must match the head of the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge wb_clk);
         if (rst_n === 1'b1 && (wb_ack_o === 1'b1 || wb_err_o === 1'b1)) begin
            if (sb.size() == 0) begin
               n_vec++;
               n_miss++;
               $display("FAIL unexpected_resp: ack=%0b err=%0b, expected no response", wb_ack_o, wb_err_o);
            end else begin
               e = sb.pop_front();
               cmp("resp_kind", {30'd0, wb_ack_o, wb_err_o}, {30'd0, ~e.is_err, e.is_err});
               if (e.chk) cmp("rd_data", wb_dat_o, e.dat);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive_idle();
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
      wb_adr_i = 32'h0;
      wb_dat_i = 32'h0;
      wb_sel_i = 4'h0;
      wb_cti_i = CTI_CLASSIC;
      wb_bte_i = BTE_LINEAR;
   endtask

   // One beat: present it, wait (bounded) for ack/err, check latency, step past the edge
   task automatic beat(input string name, input logic [2:0] cti, input logic [31:0] dat, input int exp_lat);
      int n = 0;
      bit seen = 1'b0;
      wb_cti_i = cti;
      wb_dat_i = dat;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge wb_clk);
         if (wb_ack_o === 1'b1 || wb_err_o === 1'b1) begin
            seen = 1'b1;
            break;
         end
         n++;
      end
      if (!seen) begin
         n_vec++;
         n_miss++;
         $display("FAIL %s_timeout: no ack/err within 8 clk, expected one", name);
      end else begin
         cmp({name, "_lat"}, 32'(n), 32'(exp_lat));
      end
      @(posedge wb_clk);
      #1;
   endtask

   // Request held one more clk after the final ack: slave must not ack it
   task automatic gap_check();
      @(negedge wb_clk);
      cmp("ack_gap", {31'd0, wb_ack_o}, 32'd0);
      @(posedge wb_clk);
      #1;
      drive_idle();
      @(posedge wb_clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      sb.push_back(mk(1'b0, 1'b0, 32'h0));
      wb_we_i  = 1'b1;
      wb_adr_i = adr;
      wb_sel_i = sel;
      wb_bte_i = BTE_LINEAR;
      beat("wr", CTI_CLASSIC, dat, 1);
      gap_check();
   endtask

   task automatic rd(input logic [31:0] adr, input logic [31:0] exp);
      sb.push_back(mk(1'b0, 1'b1, exp));
      wb_we_i  = 1'b0;
      wb_adr_i = adr;
      wb_sel_i = 4'hF;
      wb_bte_i = BTE_LINEAR;
      beat("rd", CTI_CLASSIC, 32'h0, 1);
      gap_check();
   endtask

   initial begin
      drive_idle();
      rst_n = 1'b0;
      #12;
      cmp("rst_ack", {31'd0, wb_ack_o}, 32'd0);
      cmp("rst_err", {31'd0, wb_err_o}, 32'd0);
      cmp("rst_rty", {31'd0, wb_rty_o}, 32'd0);
      cmp("rst_dat", wb_dat_o, 32'h0);
      rst_n = 1'b1;
      @(posedge wb_clk);
      #1;

      // Classic write then read
      wr(32'h10, 32'h1122_3344, 4'b1111);
      rd(32'h10, 32'h1122_3344);

      // Byte-lane write over zero
      wr(32'h20, 32'h0000_0000, 4'b1111);
      wr(32'h20, 32'hAABB_CCDD, 4'b0101);
      rd(32'h20, 32'h00BB_00DD);

      // Preload words 0..7 with their index, plus the top two words
      for (int i = 0; i < 8; i++) wr(32'(i * 4), 32'(i), 4'b1111);
      wr(32'hF8, 32'h3E3E_3E3E, 4'b1111);
      wr(32'hFC, 32'h3F3F_3F3F, 4'b1111);

      // Linear incrementing read burst from word 1
      sb.push_back(mk(1'b0, 1'b1, 32'd1));
      sb.push_back(mk(1'b0, 1'b1, 32'd2));
      sb.push_back(mk(1'b0, 1'b1, 32'd3));
      sb.push_back(mk(1'b0, 1'b1, 32'd4));
      wb_we_i  = 1'b0;
      wb_adr_i = 32'h04;
      wb_sel_i = 4'hF;
      wb_bte_i = BTE_LINEAR;
      beat("lin", CTI_INCR, 32'h0, 1);
      beat("lin", CTI_INCR, 32'h0, 0);
      beat("lin", CTI_INCR, 32'h0, 0);
      beat("lin", CTI_EOB,  32'h0, 0);
      gap_check();

      // Wrap-4 read burst from word 2
      sb.push_back(mk(1'b0, 1'b1, 32'd2));
      sb.push_back(mk(1'b0, 1'b1, 32'd3));
      sb.push_back(mk(1'b0, 1'b1, 32'd0));
      sb.push_back(mk(1'b0, 1'b1, 32'd1));
      wb_adr_i = 32'h08;
      wb_bte_i = BTE_WRAP4;
      beat("wrap4", CTI_INCR, 32'h0, 1);
      beat("wrap4", CTI_INCR, 32'h0, 0);
      beat("wrap4", CTI_INCR, 32'h0, 0);
      beat("wrap4", CTI_EOB,  32'h0, 0);
      gap_check();

      // Wrap-8 read burst from word 6 crosses back to word 0
      sb.push_back(mk(1'b0, 1'b1, 32'd6));
      sb.push_back(mk(1'b0, 1'b1, 32'd7));
      sb.push_back(mk(1'b0, 1'b1, 32'd0));
      wb_adr_i = 32'h18;
      wb_bte_i = BTE_WRAP8;
      beat("wrap8", CTI_INCR, 32'h0, 1);
      beat("wrap8", CTI_INCR, 32'h0, 0);
      beat("wrap8", CTI_EOB,  32'h0, 0);
      gap_check();

      // Out-of-range classic reads
      sb.push_back(mk(1'b1, 1'b0, 32'h0));
      wb_adr_i = 32'h100;
      wb_bte_i = BTE_LINEAR;
      beat("err_cls", CTI_CLASSIC, 32'h0, 1);
      drive_idle();
      @(posedge wb_clk);
      #1;
      sb.push_back(mk(1'b1, 1'b0, 32'h0));
      wb_adr_i = 32'h8000_0010;
      wb_sel_i = 4'hF;
      beat("err_hi", CTI_CLASSIC, 32'h0, 1);
      drive_idle();
      @(posedge wb_clk);
      #1;

      // Linear burst running off the top of the RAM errors on beat 3
      sb.push_back(mk(1'b0, 1'b1, 32'h3E3E_3E3E));
      sb.push_back(mk(1'b0, 1'b1, 32'h3F3F_3F3F));
      sb.push_back(mk(1'b1, 1'b0, 32'h0));
      wb_adr_i = 32'hF8;
      wb_sel_i = 4'hF;
      wb_bte_i = BTE_LINEAR;
      beat("top", CTI_INCR, 32'h0, 1);
      beat("top", CTI_INCR, 32'h0, 0);
      beat("top", CTI_INCR, 32'h0, 0);
      drive_idle();
      @(posedge wb_clk);
      #1;

      // Write burst with master wait states, then abandoned by dropping cyc
      sb.push_back(mk(1'b0, 1'b0, 32'h0));
      sb.push_back(mk(1'b0, 1'b0, 32'h0));
      wb_we_i  = 1'b1;
      wb_adr_i = 32'h00;
      wb_sel_i = 4'hF;
      wb_bte_i = BTE_LINEAR;
      beat("wst", CTI_INCR, 32'hA0A0_A0A0, 1);
      wb_stb_i = 1'b0;
      wb_dat_i = 32'hDEAD_BEEF;
      repeat (2) begin
         @(negedge wb_clk);
         cmp("wait_ack", {31'd0, wb_ack_o}, 32'd0);
      end
      @(posedge wb_clk);
      #1;
      beat("wst", CTI_INCR, 32'hB1B1_B1B1, 0);
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_dat_i = 32'hDEAD_BEEF;
      @(posedge wb_clk);
      #1;
      drive_idle();
      @(posedge wb_clk);
      #1;
      rd(32'h00, 32'hA0A0_A0A0);
      rd(32'h04, 32'hB1B1_B1B1);
      rd(32'h08, 32'd2);

      // Reset asserted mid write burst
      sb.push_back(mk(1'b0, 1'b0, 32'h0));
      wb_we_i  = 1'b1;
      wb_adr_i = 32'h18;
      wb_sel_i = 4'hF;
      wb_bte_i = BTE_LINEAR;
      beat("rstb", CTI_INCR, 32'h6666_0000, 1);
      wb_dat_i = 32'h7777_0000;
      #1;
      rst_n = 1'b0;
      #1;
      cmp("midrst_ack", {31'd0, wb_ack_o}, 32'd0);
      cmp("midrst_err", {31'd0, wb_err_o}, 32'd0);
      @(posedge wb_clk);
      #1;
      drive_idle();
      #2;
      rst_n = 1'b1;
      @(posedge wb_clk);
      #1;
      rd(32'h18, 32'h6666_0000);
      rd(32'h1C, 32'd7);

      repeat (3) @(posedge wb_clk);
      cmp("sb_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
